fir_unfold_param: RTL

//   Parametrised P-lane unfolded, pipelined N-tap direct-form FIR; successor to the fixed 3-lane, 11-tap, 10-bit filter.

---
 rtl/fir_unfold_param.sv | 115 +++++++++++
 1 files changed

// File: rtl/fir_unfold_param.sv
// P-lane unfolded, pipelined NT-tap direct-form FIR with a double-buffered coefficient bank.
// Three register stages: sample window, products, quantised sum.
`timescale 1ns/1ps
module fir_unfold_param #(
  parameter int W   = 10,
  parameter int NT  = 11,
  parameter int P   = 3,
  parameter int SAT = 1,
  localparam int AW = $clog2(NT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vin,
  input  logic [P*W-1:0] din,
  input  logic           coef_we,
  input  logic [AW-1:0]  coef_addr,
  input  logic [W-1:0]   coef_data,
  input  logic           coef_swap,
  output logic           vout,
  output logic [P*W-1:0] dout,
  output logic [P-1:0]   ovf
);

  localparam int WL = P + NT - 1;       // current block plus NT-1 history samples
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + $clog2(NT);
  localparam int QW = SW - (W - 1);

  // Handshake: vin qualifies din for one cycle; there is no ready, every valid
  // block is accepted. vout qualifies dout/ovf, which hold between valid blocks.

  logic signed [W-1:0]  shadow [NT];
  logic signed [W-1:0]  active [NT];
  logic signed [W-1:0]  win    [WL];
  logic signed [PW-1:0] prod   [P][NT];
  logic                 v1, v2;

  logic signed [SW-1:0] acc [P];
  logic signed [QW-1:0] q   [P];
  logic [W-1:0]         res [P];
  logic [P-1:0]         fit;

  // Nonblocking copy: a write in the swap cycle lands after the copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (coef_swap)
        for (int i = 0; i < NT; i++) active[i] <= shadow[i];
      if (coef_we && (int'(coef_addr) < NT))
        shadow[coef_addr] <= coef_data;
    end
  end

  // win[0] is the newest sample (lane P-1); older samples sit at higher indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int m = 0; m < WL; m++) win[m] <= '0;
    end else begin
      v1 <= vin;
      if (vin) begin
        for (int m = 0; m < P; m++) win[m] <= din[(P-1-m)*W +: W];
        for (int m = P; m < WL; m++) win[m] <= win[m-P];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      for (int j = 0; j < P; j++)
        for (int i = 0; i < NT; i++) prod[j][i] <= '0;
    end else begin
      v2 <= v1;
      if (v1)
        for (int j = 0; j < P; j++)
          for (int i = 0; i < NT; i++)
            prod[j][i] <= PW'(active[i]) * PW'(win[P-1-j+i]);
    end
  end

  always_comb begin
    for (int j = 0; j < P; j++) begin
      acc[j] = '0;
      for (int i = 0; i < NT; i++) acc[j] = acc[j] + SW'(prod[j][i]);
      q[j]   = QW'(acc[j] >>> (W - 1));
      // Fits in W bits when every bit above the W-bit sign is a sign copy.
      fit[j] = (&q[j][QW-1:W-1]) | ~(|q[j][QW-1:W-1]);
      if ((SAT != 0) && !fit[j])
        res[j] = q[j][QW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
        res[j] = q[j][W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vout <= 1'b0;
      dout <= '0;
      ovf  <= '0;
    end else begin
      vout <= v2;
      if (v2)
        for (int j = 0; j < P; j++) begin
          dout[j*W +: W] <= res[j];
          ovf[j]         <= ~fit[j];
        end
    end
  end

endmodule
